// File: rtl/max7219_display_tx.sv
// MAX7219 serial transmitter: config sequence after reset, then 8-digit refreshes.
// Define MAX7219_BCD_DECODE_EN for Code-B decode; the default build sends raw segments.
module max7219_display_tx #(
    parameter int         CLK_DIV   = 2,
    parameter logic [3:0] INTENSITY = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic        i_update_stb,
    input  logic [63:0] i_digits,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_serial_clk,
    output logic        o_serial_dout,
    output logic        o_serial_load
);

    localparam int DW = $clog2(2 * CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);

`ifdef MAX7219_BCD_DECODE_EN
    localparam logic [7:0] DECODE = 8'hFF;
`else
    localparam logic [7:0] DECODE = 8'h00;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_REFRESH
    } state_t;

    typedef enum logic [1:0] {
        SB_SHIFT,
        SB_LATCH,
        SB_GAP,
        SB_HOLD
    } sub_t;

    state_t        state;
    sub_t          sub;
    logic [DW-1:0] div_cnt;
    logic [3:0]    bit_cnt;
    logic [2:0]    word_cnt;
    logic [15:0]   shift_reg;
    logic [63:0]   snap;
    logic          pending;
    logic          init_done;
    logic          sclk;
    logic          dout;
    logic          load;

    function automatic logic [7:0] digit_code(input logic [7:0] d);
`ifdef MAX7219_BCD_DECODE_EN
        return {d[7], 3'b000, d[3:0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [15:0] build_word(
        input logic        init_seq,
        input logic [2:0]  idx,
        input logic [63:0] digits
    );
        logic [15:0] w;
        w = 16'h0000;
        if (init_seq) begin
            case (idx)
                3'd0:    w = 16'h0C01;
                3'd1:    w = 16'h0F00;
                3'd2:    w = 16'h0B07;
                3'd3:    w = {8'h09, DECODE};
                default: w = {12'h0A0, INTENSITY};
            endcase
        end else begin
            w = {4'h0, {1'b0, idx} + 4'd1,
                 digit_code(digits[{idx, 3'b000} +: 8])};
        end
        return w;
    endfunction

    logic        gap_end;
    logic        last_word;
    logic        go_init;
    logic        go_refresh;
    logic        enter_refresh;
    logic        seq_end;
    logic        start;
    logic        next_init;
    logic [2:0]  next_idx;
    logic [63:0] next_src;
    logic [15:0] next_word;

    always_comb begin
        gap_end       = (sub == SB_GAP) && (div_cnt == DIV_LAST);
        last_word     = (state == ST_INIT) ? (word_cnt == 3'd4)
                                           : (word_cnt == 3'd7);
        go_init       = (state == ST_IDLE) && i_en && !init_done;
        go_refresh    = (state == ST_IDLE) && i_en && init_done
                        && (i_update_stb || pending);
        enter_refresh = go_refresh
                        || ((state == ST_INIT) && gap_end && last_word);
        seq_end       = (state == ST_REFRESH) && gap_end && last_word;
        // Next word starts at a word boundary only while enabled
        start         = go_init || go_refresh
                        || (i_en && (state != ST_IDLE) && !seq_end
                            && (gap_end || (sub == SB_HOLD)));
        next_init     = go_init || ((state == ST_INIT) && !enter_refresh);
        if (go_init || enter_refresh) begin
            next_idx = 3'd0;
        end else if (sub == SB_HOLD) begin
            next_idx = word_cnt;
        end else begin
            next_idx = word_cnt + 3'd1;
        end
        next_src  = enter_refresh ? i_digits : snap;
        next_word = build_word(next_init, next_idx, next_src);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            sub       <= SB_HOLD;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            snap      <= '0;
            pending   <= 1'b0;
            init_done <= 1'b0;
            sclk      <= 1'b0;
            dout      <= 1'b0;
            load      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go_init) begin
                        state <= ST_INIT;
                    end else if (go_refresh) begin
                        state <= ST_REFRESH;
                    end
                end
                ST_INIT: begin
                    if (enter_refresh) begin
                        state     <= ST_REFRESH;
                        init_done <= 1'b1;
                    end
                end
                ST_REFRESH: begin
                    if (seq_end) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (enter_refresh) begin
                snap <= i_digits;
            end

            if (go_init || enter_refresh) begin
                word_cnt <= '0;
            end else if (gap_end && !last_word) begin
                word_cnt <= word_cnt + 3'd1;
            end

            // Strobes that cannot be served right now coalesce here
            if (go_refresh) begin
                pending <= 1'b0;
            end else if (i_update_stb) begin
                pending <= 1'b1;
            end

            if (start) begin
                sub       <= SB_SHIFT;
                div_cnt   <= '0;
                bit_cnt   <= '0;
                shift_reg <= next_word;
                dout      <= next_word[15];
                sclk      <= 1'b0;
                load      <= 1'b0;
            end else begin
                unique case (sub)
                    SB_SHIFT: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            sclk    <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                sub  <= SB_LATCH;
                                load <= 1'b1;
                                dout <= 1'b0;
                            end else begin
                                bit_cnt   <= bit_cnt + 4'd1;
                                shift_reg <= {shift_reg[14:0], 1'b0};
                                dout      <= shift_reg[14];
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                            if (div_cnt == DIV_HALF) begin
                                sclk <= 1'b1;
                            end
                        end
                    end
                    SB_LATCH: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            load    <= 1'b0;
                            sub     <= SB_GAP;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SB_GAP: begin
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            sub     <= SB_HOLD;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SB_HOLD: begin
                    end
                    default: sub <= SB_HOLD;
                endcase
            end
        end
    end

    assign o_busy        = (state != ST_IDLE) || pending;
    assign o_init_done   = init_done;
    assign o_serial_clk  = sclk;
    assign o_serial_dout = dout;
    assign o_serial_load = load;

endmodule

// File: tb/tb_max7219_display_tx.sv
// Directed bench for max7219_display_tx with a MAX7219 receiver mock.
// Expected words follow MAX7219_BCD_DECODE_EN the same way as the design.
module tb_max7219_display_tx;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_en;
    logic        i_update_stb;
    logic [63:0] i_digits;
    logic        o_busy;
    logic        o_init_done;
    logic        o_serial_clk;
    logic        o_serial_dout;
    logic        o_serial_load;

    max7219_display_tx dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_en          (i_en),
        .i_update_stb  (i_update_stb),
        .i_digits      (i_digits),
        .o_busy        (o_busy),
        .o_init_done   (o_init_done),
        .o_serial_clk  (o_serial_clk),
        .o_serial_dout (o_serial_dout),
        .o_serial_load (o_serial_load)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

`ifdef MAX7219_BCD_DECODE_EN
    localparam logic [15:0] DECODE_WORD = 16'h09FF;
    localparam logic [15:0] FF_WORD     = 16'h018F;
`else
    localparam logic [15:0] DECODE_WORD = 16'h0900;
    localparam logic [15:0] FF_WORD     = 16'h01FF;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] rx_sr = 16'h0;
    logic [15:0] rx_q[$];
    int          rise_q[$];
    int          width_q[$];
    int          last_rise = 0;
    int          sclk_rises = 0;
    int          init_at_load = -1;

    always @(posedge i_clk) cyc = cyc + 1;

    always @(posedge o_serial_clk) begin
        rx_sr = {rx_sr[14:0], o_serial_dout};
        sclk_rises = sclk_rises + 1;
    end

    always @(posedge o_serial_load) begin
        rx_q.push_back(rx_sr);
        rise_q.push_back(cyc);
        last_rise = cyc;
    end

    always @(negedge o_serial_load) width_q.push_back(cyc - last_rise);

    always @(posedge o_init_done) init_at_load = rx_q.size();

    typedef struct packed {
        logic [63:0]       digits;
        logic [7:0][15:0]  exp;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rise_q.delete();
        width_q.delete();
    endtask

    task automatic wait_idle(input int bound, input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_loads(input int target, input int bound,
                              input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge i_clk);
            if (rx_q.size() >= target) begin
                done = 1'b1;
                break;
            end
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic pulse_stb();
        @(negedge i_clk);
        i_update_stb = 1'b1;
        @(negedge i_clk);
        i_update_stb = 1'b0;
    endtask

    task automatic check_refresh(input vec_t v, input int base,
                                 input string name);
        for (int k = 0; k < 8; k++) begin
            if (rx_q.size() > base + k) begin
                check(name, 32'(rx_q[base + k]), 32'(v.exp[k]));
            end else begin
                check(name, 32'hDEAD, 32'(v.exp[k]));
            end
        end
    endtask

    int n;
    int s0;

    initial begin
        vecs[0].digits = 64'h0908070605040302;
        vecs[0].exp    = {16'h0809, 16'h0708, 16'h0607, 16'h0506,
                          16'h0405, 16'h0304, 16'h0203, 16'h0102};
        vecs[1].digits = 64'h8000000000000001;
        vecs[1].exp    = {16'h0880, 16'h0700, 16'h0600, 16'h0500,
                          16'h0400, 16'h0300, 16'h0200, 16'h0101};
        vecs[2].digits = 64'h8705830481028003;
        vecs[2].exp    = {16'h0887, 16'h0705, 16'h0683, 16'h0504,
                          16'h0481, 16'h0302, 16'h0280, 16'h0103};

        i_reset_n    = 1'b0;
        i_en         = 1'b0;
        i_update_stb = 1'b0;
        i_digits     = 64'h0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs",
              {27'h0, o_serial_clk, o_serial_dout, o_serial_load,
               o_busy, o_init_done}, 32'h0);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("idle_disabled_busy", 32'(o_busy), 32'd0);

        // Power-up: INIT then automatic refresh
        clear_rx();
        i_en = 1'b1;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            if (o_busy) n++;
            else if (n > 0) break;
        end
        check("busy_duration", 32'(n), 32'd936);
        check("powerup_loads", 32'(rx_q.size()), 32'd13);
        if (rx_q.size() >= 5) begin
            check("init_w0", 32'(rx_q[0]), 32'h0C01);
            check("init_w1", 32'(rx_q[1]), 32'h0F00);
            check("init_w2", 32'(rx_q[2]), 32'h0B07);
            check("init_w3", 32'(rx_q[3]), 32'(DECODE_WORD));
            check("init_w4", 32'(rx_q[4]), 32'h0A0F);
        end
        check("init_done_after", 32'(init_at_load), 32'd5);
        check("init_done_level", 32'(o_init_done), 32'd1);

        // Table-driven refreshes from IDLE
        for (int v = 0; v < 3; v++) begin
            clear_rx();
            i_digits = vecs[v].digits;
            @(negedge i_clk);
            i_update_stb = 1'b1;
            n = 0;
            do begin
                @(posedge i_clk);
                n++;
                #1;
                if (n == 1) i_update_stb = 1'b0;
            end while (!o_serial_clk && n < 50);
            check("sclk_latency", 32'(n), 32'd3);
            wait_idle(1000, "refresh_idle");
            check("refresh_loads", 32'(rx_q.size()), 32'd8);
            check_refresh(vecs[v], 0, "refresh_word");
            for (int k = 0; k < 8; k++) begin
                if (width_q.size() > k)
                    check("load_width", 32'(width_q[k]), 32'd4);
                if (k < 7 && rise_q.size() > k + 1)
                    check("load_spacing", 32'(rise_q[k+1] - rise_q[k]),
                          32'd72);
            end
        end

        // Strobes mid-refresh coalesce; snapshot protects current refresh
        clear_rx();
        i_digits = vecs[1].digits;
        pulse_stb();
        wait_loads(2, 400, "coalesce_start");
        i_digits = vecs[2].digits;
        pulse_stb();
        repeat (5) @(negedge i_clk);
        pulse_stb();
        repeat (20) @(negedge i_clk);
        pulse_stb();
        check("pending_busy", 32'(o_busy), 32'd1);
        wait_idle(3000, "coalesce_idle");
        check("coalesce_loads", 32'(rx_q.size()), 32'd16);
        check_refresh(vecs[1], 0, "coalesce_old");
        check_refresh(vecs[2], 8, "coalesce_new");

        // Disable during word 3, resume at word 4
        clear_rx();
        i_digits = vecs[0].digits;
        pulse_stb();
        wait_loads(2, 400, "pause_start");
        repeat (20) @(negedge i_clk);
        i_en = 1'b0;
        wait_loads(3, 200, "pause_word3");
        repeat (10) @(negedge i_clk);
        s0 = sclk_rises;
        repeat (480) @(negedge i_clk);
        check("pause_no_sclk", 32'(sclk_rises - s0), 32'd0);
        check("pause_loads", 32'(rx_q.size()), 32'd3);
        check("pause_busy", 32'(o_busy), 32'd1);
        i_en = 1'b1;
        wait_idle(1000, "pause_idle");
        check("pause_total_loads", 32'(rx_q.size()), 32'd8);
        check_refresh(vecs[0], 0, "pause_word");

        // Asynchronous reset mid-word, INIT reruns
        clear_rx();
        pulse_stb();
        repeat (30) @(negedge i_clk);
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("async_reset",
              {27'h0, o_serial_clk, o_serial_dout, o_serial_load,
               o_busy, o_init_done}, 32'h0);
        @(negedge i_clk);
        clear_rx();
        i_reset_n = 1'b1;
        wait_loads(1, 200, "restart_first");
        if (rx_q.size() >= 1)
            check("restart_w0", 32'(rx_q[0]), 32'h0C01);
        wait_idle(3000, "restart_idle");
        check("restart_loads", 32'(rx_q.size()), 32'd13);
        if (rx_q.size() >= 4)
            check("restart_decode", 32'(rx_q[3]), 32'(DECODE_WORD));

        // Digit 0 = 0xFF shows the raw/decode difference
        clear_rx();
        i_digits = 64'h00000000000000FF;
        pulse_stb();
        wait_idle(1000, "ff_idle");
        if (rx_q.size() >= 1)
            check("ff_word", 32'(rx_q[0]), 32'(FF_WORD));
        else
            check("ff_word", 32'hDEAD, 32'(FF_WORD));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
